// File: rtl/seg_scan_decoder.sv
// Decodes a multiplexed 4-digit seven-segment scan back into a 16-bit hex frame.
// Optional decimal-point capture is enabled with `define SEG_SCAN_DP_EN.
`timescale 1ns/1ps
module seg_scan_decoder #(
  parameter int unsigned STABLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
`ifdef SEG_SCAN_DP_EN
  input  logic        dp,
  output logic [3:0]  dp_out,
`endif
  output logic [15:0] value,
  output logic [3:0]  digit_err,
  output logic        frame_valid,
  output logic        stale
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_HELD   = 2'd2;

  localparam logic [7:0]  STB = 8'(STABLE_CYC);
  localparam logic [19:0] TMO = 20'(TIMEOUT_CYC);

  logic [6:0]  seg_s1_q, seg_s2_q, seg_p_q;
  logic [3:0]  an_s1_q, an_s2_q, an_p_q;
  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d, cnt_nxt;
  logic [19:0] to_q, to_d;
  logic [3:0]  mask_q, mask_d;
  logic [15:0] slot_v_q, slot_v_d;
  logic [3:0]  slot_e_q, slot_e_d;
  logic [15:0] value_q, value_d;
  logic [3:0]  err_q, err_d;
  logic        fv_q, fv_d;
  logic        stale_q, stale_d;
  logic        onehot, same, cap, done, tmo;
  logic [1:0]  idx;
  logic [4:0]  dec;

  function automatic logic [4:0] glyph(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'b1111110: r = 5'h00;
      7'b0110000: r = 5'h01;
      7'b1101101: r = 5'h02;
      7'b1111001: r = 5'h03;
      7'b0110011: r = 5'h04;
      7'b1011011: r = 5'h05;
      7'b1011111: r = 5'h06;
      7'b1110000: r = 5'h07;
      7'b1111111: r = 5'h08;
      7'b1111011: r = 5'h09;
      7'b1110111: r = 5'h0a;
      7'b0011111: r = 5'h0b;
      7'b1001110: r = 5'h0c;
      7'b0111101: r = 5'h0d;
      7'b1001111: r = 5'h0e;
      7'b1000111: r = 5'h0f;
      default:    r = 5'h10;
    endcase
    return r;
  endfunction

  always_comb begin
    onehot = 1'b1;
    idx    = 2'd0;
    case (an_s2_q)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: onehot = 1'b0;
    endcase
  end

  assign dec     = glyph(seg_s2_q);
  assign same    = (seg_s2_q == seg_p_q) && (an_s2_q == an_p_q);
  assign cnt_nxt = same ? cnt_q + 8'd1 : 8'd1;
  assign done    = (mask_q == 4'hf);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (onehot) begin
          state_d = S_SETTLE;
          cnt_d   = 8'd1;
        end
      end
      S_SETTLE: begin
        if (!onehot) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_nxt == STB) begin
          cap     = 1'b1;
          state_d = S_HELD;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_nxt;
        end
      end
      S_HELD: begin
        // only a digit-enable change re-arms capture
        if (an_s2_q != an_p_q) begin
          state_d = onehot ? S_SETTLE : S_IDLE;
          cnt_d   = onehot ? 8'd1 : 8'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  assign tmo = (to_q == TMO) && !cap;

  always_comb begin
    to_d     = cap ? 20'd0 : (to_q == TMO ? to_q : to_q + 20'd1);
    slot_v_d = slot_v_q;
    slot_e_d = slot_e_q;
    mask_d   = mask_q;
    value_d  = value_q;
    err_d    = err_q;
    fv_d     = done;
    stale_d  = stale_q;
    if (done || tmo) mask_d = 4'h0;
    if (tmo) stale_d = 1'b1;
    if (cap) begin
      slot_v_d[{idx, 2'b00} +: 4] = dec[3:0];
      slot_e_d[idx] = dec[4];
      mask_d[idx]   = 1'b1;
    end
    if (done) begin
      value_d = slot_v_q;
      err_d   = slot_e_q;
      stale_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_s1_q <= 7'h00;
      seg_s2_q <= 7'h00;
      seg_p_q  <= 7'h00;
      an_s1_q  <= 4'hf;
      an_s2_q  <= 4'hf;
      an_p_q   <= 4'hf;
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      to_q     <= 20'd0;
      mask_q   <= 4'h0;
      slot_v_q <= 16'h0;
      slot_e_q <= 4'h0;
      value_q  <= 16'h0;
      err_q    <= 4'h0;
      fv_q     <= 1'b0;
      stale_q  <= 1'b1;
    end else begin
      seg_s1_q <= seg;
      seg_s2_q <= seg_s1_q;
      seg_p_q  <= seg_s2_q;
      an_s1_q  <= an;
      an_s2_q  <= an_s1_q;
      an_p_q   <= an_s2_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      to_q     <= to_d;
      mask_q   <= mask_d;
      slot_v_q <= slot_v_d;
      slot_e_q <= slot_e_d;
      value_q  <= value_d;
      err_q    <= err_d;
      fv_q     <= fv_d;
      stale_q  <= stale_d;
    end
  end

`ifdef SEG_SCAN_DP_EN
  logic       dp_s1_q, dp_s2_q;
  logic [3:0] dp_slot_q, dp_slot_d;
  logic [3:0] dp_out_q, dp_out_d;

  always_comb begin
    dp_slot_d = dp_slot_q;
    dp_out_d  = dp_out_q;
    if (cap) dp_slot_d[idx] = dp_s2_q;
    if (done) dp_out_d = dp_slot_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_s1_q   <= 1'b0;
      dp_s2_q   <= 1'b0;
      dp_slot_q <= 4'h0;
      dp_out_q  <= 4'h0;
    end else begin
      dp_s1_q   <= dp;
      dp_s2_q   <= dp_s1_q;
      dp_slot_q <= dp_slot_d;
      dp_out_q  <= dp_out_d;
    end
  end

  assign dp_out = dp_out_q;
`endif

  assign value       = value_q;
  assign digit_err   = err_q;
  assign frame_valid = fv_q;
  assign stale       = stale_q;

endmodule
